// File: rtl/axi_lite_alu_pkg.sv
// rtl/axi_lite_alu_pkg.sv - register map, op encodings, response codes and bit indices
package axi_lite_alu_pkg;

  localparam logic [2:0] REG_OPA       = 3'd0;
  localparam logic [2:0] REG_OPB       = 3'd1;
  localparam logic [2:0] REG_CTRL      = 3'd2;
  localparam logic [2:0] REG_STATUS    = 3'd3;
  localparam logic [2:0] REG_RESULT_LO = 3'd4;
  localparam logic [2:0] REG_RESULT_HI = 3'd5;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_XOR = 2'b11
  } alu_op_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int CTRL_START   = 0;
  localparam int CTRL_OP_LO   = 1;
  localparam int CTRL_OP_HI   = 2;
  localparam int CTRL_AUTO    = 3;
  localparam int CTRL_IE      = 4;
  localparam int STATUS_DONE  = 0;
  localparam int STATUS_CARRY = 1;

endpackage

// File: rtl/axi_lite_alu_regs_alu_core.sv
// rtl/axi_lite_alu_regs_alu_core.sv - registered ALU stage; loads one edge after trig
module alu_core
  import axi_lite_alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  alu_op_e               op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  trig,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  carry,
  output logic                  done_pulse
);

  logic                trig_q;
  logic [DATA_WIDTH:0] next_val;

  // The extra top bit is the carry for add and the borrow for subtract.
  always_comb begin
    next_val = '0;
    case (op)
      OP_ADD:  next_val = {1'b0, a} + {1'b0, b};
      OP_SUB:  next_val = {1'b0, a} - {1'b0, b};
      OP_AND:  next_val = {1'b0, a & b};
      OP_XOR:  next_val = {1'b0, a ^ b};
      default: next_val = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trig_q <= 1'b0;
      result <= '0;
      carry  <= 1'b0;
    end else begin
      trig_q <= trig;
      if (trig_q) begin
        {carry, result} <= next_val;
      end
    end
  end

  assign done_pulse = trig_q;

endmodule

// File: rtl/axi_lite_alu_regs.sv
// rtl/axi_lite_alu_regs.sv - AXI4-Lite slave with operand/control registers and ALU result
module axi_lite_alu_regs
  import axi_lite_alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int RESP_WIDTH = 2
) (
  input  logic                    s1_axi_aclk,
  input  logic                    s1_axi_areset,
  input  logic [ADDR_WIDTH-1:0]   s1_axi_awaddr,
  input  logic                    s1_axi_awvalid,
  output logic                    s1_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s1_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s1_axi_wstrb,
  input  logic                    s1_axi_wvalid,
  output logic                    s1_axi_wready,
  output logic [RESP_WIDTH-1:0]   s1_axi_bresp,
  output logic                    s1_axi_bvalid,
  input  logic                    s1_axi_bready,
  input  logic [ADDR_WIDTH-1:0]   s1_axi_araddr,
  input  logic                    s1_axi_arvalid,
  output logic                    s1_axi_arready,
  output logic [DATA_WIDTH-1:0]   s1_axi_rdata,
  output logic [RESP_WIDTH-1:0]   s1_axi_rresp,
  output logic                    s1_axi_rvalid,
  input  logic                    s1_axi_rready,
  output logic                    irq
);

  localparam int NB = DATA_WIDTH / 8;

  logic                  aw_held, w_held, rd_lo_q;
  logic [ADDR_WIDTH-1:0] aw_addr_q;
  logic [DATA_WIDTH-1:0] w_data_q, opa, opb, result, rd_val;
  logic [NB-1:0]         w_strb_q;
  alu_op_e               op_q;
  logic                  auto_q, ie_q, done_q, carry, done_pulse;
  logic                  commit, wr_ok, trig, rd_err;
  logic [2:0]            widx, ridx;
  logic                  unused_addr_bits;

  function automatic logic [DATA_WIDTH-1:0] merge(input logic [DATA_WIDTH-1:0] old,
                                                  input logic [DATA_WIDTH-1:0] data,
                                                  input logic [NB-1:0] strb);
    merge = old;
    for (int i = 0; i < NB; i++) begin
      if (strb[i]) merge[i*8 +: 8] = data[i*8 +: 8];
    end
  endfunction

  assign s1_axi_awready = !s1_axi_areset && !aw_held && !s1_axi_bvalid;
  assign s1_axi_wready  = !s1_axi_areset && !w_held && !s1_axi_bvalid;
  assign s1_axi_arready = !s1_axi_areset && !s1_axi_rvalid;
  assign unused_addr_bits = ^{aw_addr_q[1:0], s1_axi_araddr[1:0]};

  assign commit = aw_held && w_held;
  assign widx   = aw_addr_q[4:2];
  assign wr_ok  = ((aw_addr_q >> 5) == '0) && (widx <= REG_CTRL);
  assign trig   = commit && wr_ok &&
                  ((widx == REG_CTRL && w_strb_q[0] && w_data_q[CTRL_START]) ||
                   (widx == REG_OPB && auto_q));
  assign irq    = done_q && ie_q;

  assign ridx = s1_axi_araddr[4:2];
  always_comb begin
    rd_val = '0;
    rd_err = 1'b0;
    if ((s1_axi_araddr >> 5) != '0) begin
      rd_err = 1'b1;
    end else begin
      case (ridx)
        REG_OPA:       rd_val = opa;
        REG_OPB:       rd_val = opb;
        REG_CTRL:      rd_val = DATA_WIDTH'({ie_q, auto_q, op_q, 1'b0});
        REG_STATUS:    rd_val = DATA_WIDTH'({carry, done_q});
        REG_RESULT_LO: rd_val = result;
        REG_RESULT_HI: rd_val = DATA_WIDTH'(carry);
        default:       rd_err = 1'b1;
      endcase
    end
  end

  always_ff @(posedge s1_axi_aclk or posedge s1_axi_areset) begin
    if (s1_axi_areset) begin
      aw_held <= 1'b0; aw_addr_q <= '0;
      w_held <= 1'b0; w_data_q <= '0; w_strb_q <= '0;
      s1_axi_bvalid <= 1'b0; s1_axi_bresp <= '0;
      s1_axi_rvalid <= 1'b0; s1_axi_rresp <= '0; s1_axi_rdata <= '0; rd_lo_q <= 1'b0;
      opa <= '0; opb <= '0; op_q <= OP_ADD; auto_q <= 1'b0; ie_q <= 1'b0; done_q <= 1'b0;
    end else begin
      if (s1_axi_awvalid && s1_axi_awready) begin
        aw_held   <= 1'b1;
        aw_addr_q <= s1_axi_awaddr;
      end
      if (s1_axi_wvalid && s1_axi_wready) begin
        w_held   <= 1'b1;
        w_data_q <= s1_axi_wdata;
        w_strb_q <= s1_axi_wstrb;
      end
      if (commit) begin
        aw_held       <= 1'b0;
        w_held        <= 1'b0;
        s1_axi_bvalid <= 1'b1;
        s1_axi_bresp  <= wr_ok ? RESP_WIDTH'(RESP_OKAY) : RESP_WIDTH'(RESP_SLVERR);
        if (wr_ok) begin
          case (widx)
            REG_OPA: opa <= merge(opa, w_data_q, w_strb_q);
            REG_OPB: opb <= merge(opb, w_data_q, w_strb_q);
            default: if (w_strb_q[0]) begin
              op_q   <= alu_op_e'(w_data_q[CTRL_OP_HI:CTRL_OP_LO]);
              auto_q <= w_data_q[CTRL_AUTO];
              ie_q   <= w_data_q[CTRL_IE];
            end
          endcase
        end
      end else if (s1_axi_bvalid && s1_axi_bready) begin
        s1_axi_bvalid <= 1'b0;
      end

      if (s1_axi_arvalid && s1_axi_arready) begin
        s1_axi_rvalid <= 1'b1;
        s1_axi_rdata  <= rd_val;
        s1_axi_rresp  <= rd_err ? RESP_WIDTH'(RESP_SLVERR) : RESP_WIDTH'(RESP_OKAY);
        rd_lo_q       <= !rd_err && (ridx == REG_RESULT_LO);
      end else if (s1_axi_rvalid && s1_axi_rready) begin
        s1_axi_rvalid <= 1'b0;
      end

      // A completing computation wins over a same-edge clear.
      if (done_pulse) begin
        done_q <= 1'b1;
      end else if (trig || (s1_axi_rvalid && s1_axi_rready && rd_lo_q)) begin
        done_q <= 1'b0;
      end
    end
  end

  alu_core #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
    .clk        (s1_axi_aclk),
    .rst        (s1_axi_areset),
    .op         (op_q),
    .a          (opa),
    .b          (opb),
    .trig       (trig),
    .result     (result),
    .carry      (carry),
    .done_pulse (done_pulse)
  );

endmodule
